// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared FSM state type and sizing helpers for the SDF FFT
//                control sequencer.
//  Revision    : 1.0
// ============================================================================
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // Sample-in to result-out latency: reorder depth plus butterfly pipelines.
    function automatic int lat_total(input int log2n, input int stage_lat);
        return ((1 << log2n) - 1) + log2n * stage_lat;
    endfunction

    function automatic int tw_width(input int log2n);
        return log2n - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_stage_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_stage_ctl
//  Description : One SDF stage controller: enable delay, position counter,
//                butterfly select and (with FFT_SEQ_TWIDDLE_EN) twiddle address.
//  Revision    : 1.0
// ============================================================================
module fft_stage_ctl
    import fft_pkg::*;
#(
    parameter int LOG2N     = 4,
    parameter int STAGE_LAT = 3,
    parameter int STAGE     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_clr,
    input  logic                                 i_en_prev,
    output logic                                 o_en,
    output logic                                 o_sel,
    output logic [fft_pkg::tw_width(LOG2N)-1:0]  o_tw
);

    logic             w_en;
    logic [LOG2N-1:0] r_cnt;

    generate
        if (STAGE == 0) begin : g_head
            assign w_en = i_en_prev;
        end else begin : g_dly
            logic [STAGE_LAT-1:0] r_dly;
            always_ff @(posedge clk) begin
                if (rst || i_clr) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= (r_dly << 1) | STAGE_LAT'(i_en_prev);
                end
            end
            assign w_en = r_dly[STAGE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_en  = w_en;
    assign o_sel = w_en & r_cnt[LOG2N-1-STAGE];

`ifdef FFT_SEQ_TWIDDLE_EN
    localparam int TWW = tw_width(LOG2N);
    generate
        if (STAGE < LOG2N - 1) begin : g_tw
            localparam int MBITS = LOG2N - 1 - STAGE;
            logic [MBITS-1:0] w_low;
            assign w_low = r_cnt[MBITS-1:0];
            assign o_tw  = (w_en && !o_sel) ? (TWW'(w_low) << STAGE) : '0;
        end else begin : g_tw_last
            assign o_tw = '0;
        end
    endgenerate
`else
    assign o_tw = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/fft_sdf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_sdf_sequencer
//  Description : Frame/flush sequencer driving per-stage controls of an SDF FFT.
//                Twiddle addressing is built only with FFT_SEQ_TWIDDLE_EN.
//  Revision    : 1.0
// ============================================================================
module fft_sdf_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N     = 4,
    parameter int STAGE_LAT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [LOG2N-1:0]             stage_en,
    output logic [LOG2N-1:0]             bfly_sel,
    output logic [LOG2N*(LOG2N-1)-1:0]   tw_addr,
    output logic                         flush,
    output logic                         out_valid,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         err
);

    localparam int LAT_TOTAL = lat_total(LOG2N, STAGE_LAT);
    localparam int TWW       = tw_width(LOG2N);
    localparam int LCW       = $clog2(LAT_TOTAL + 1);

    state_t                    r_state;
    logic [LOG2N-1:0]          r_cnt0;
    logic [LOG2N-1:0]          r_out_idx;
    logic [LCW-1:0]            r_fcnt;
    logic [LCW-1:0]            r_lat;
    logic                      r_lat_on;
    logic                      r_out_valid;

    logic                      w_abort;
    logic                      w_quiet;
    logic                      w_acc;
    logic                      w_to_flush;
    logic                      w_flush;
    logic                      w_eff;
    logic                      w_flush_end;
    logic [LOG2N-1:0]          w_stage_en;
    logic [LOG2N-1:0]          w_sel;
    logic [LOG2N*TWW-1:0]      w_tw;

    assign w_abort    = (r_state == ST_ABORT);
    assign w_quiet    = rst | w_abort;
    assign in_ready   = rst | (r_state == ST_IDLE) | (r_state == ST_RUN);
    assign w_acc      = in_valid & in_ready & ~rst;
    // The first idle cycle on a frame boundary already counts as flush.
    assign w_to_flush = (r_state == ST_RUN) & ~in_valid & (r_cnt0 == '0);
    assign w_flush    = ~rst & ((r_state == ST_FLUSH) | w_to_flush);
    assign w_eff      = w_acc | w_flush;
    assign w_flush_end = (r_state == ST_FLUSH) && (r_fcnt == LCW'(LAT_TOTAL - 1));

    assign flush      = w_flush;
    assign err        = ~rst & (w_abort | ((r_state == ST_FLUSH) & in_valid));
    assign stage_en   = w_quiet ? '0 : w_stage_en;
    assign bfly_sel   = w_quiet ? '0 : w_sel;
    assign tw_addr    = w_quiet ? '0 : w_tw;
    assign out_valid  = ~w_quiet & r_out_valid;
    assign out_first  = out_valid & (r_out_idx == '0);
    assign out_last   = out_valid & (&r_out_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt0  <= '0;
            r_fcnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_RUN;
                        r_cnt0  <= LOG2N'(1);
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        r_cnt0 <= r_cnt0 + 1'b1;
                    end else if (r_cnt0 == '0) begin
                        r_state <= ST_FLUSH;
                        r_fcnt  <= LCW'(1);
                    end else begin
                        r_state <= ST_ABORT;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_end) begin
                        r_state <= ST_IDLE;
                        r_fcnt  <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt0  <= '0;
                    r_fcnt  <= '0;
                end
            endcase
        end
    end

    // Runs are whole frames and drain exactly when flush ends, so output
    // validity is a start delay plus a stop at flush end.
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_lat_on    <= 1'b0;
            r_lat       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_lat_on <= 1'b1;
                r_lat    <= LCW'(1);
            end else if (r_lat_on) begin
                if (r_lat == LCW'(LAT_TOTAL - 1)) begin
                    r_lat_on    <= 1'b0;
                    r_lat       <= '0;
                    r_out_valid <= 1'b1;
                end else begin
                    r_lat <= r_lat + 1'b1;
                end
            end
            if (w_flush_end) begin
                r_out_valid <= 1'b0;
                r_out_idx   <= '0;
            end else if (r_out_valid) begin
                r_out_idx <= r_out_idx + 1'b1;
            end
        end
    end

    generate
        for (genvar s = 0; s < LOG2N; s++) begin : g_stage
            logic w_prev;
            if (s == 0) begin : g_src_in
                assign w_prev = w_eff;
            end else begin : g_src_chain
                assign w_prev = w_stage_en[s-1];
            end
            fft_stage_ctl #(
                .LOG2N     (LOG2N),
                .STAGE_LAT (STAGE_LAT),
                .STAGE     (s)
            ) u_ctl (
                .clk       (clk),
                .rst       (rst),
                .i_clr     (w_abort),
                .i_en_prev (w_prev),
                .o_en      (w_stage_en[s]),
                .o_sel     (w_sel[s]),
                .o_tw      (w_tw[s*TWW +: TWW])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_sdf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_sdf_sequencer
//  Description : Randomized and directed bench for fft_sdf_sequencer (N=16).
//  Revision    : 1.0
// ============================================================================
module tb_fft_sdf_sequencer;

    localparam int LOG2N     = 4;
    localparam int STAGE_LAT = 3;
    localparam int N         = 16;
    localparam int LATT      = 27;
    localparam int TWW       = 3;
    localparam int HMAX      = 8192;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [LOG2N-1:0]         stage_en;
    logic [LOG2N-1:0]         bfly_sel;
    logic [LOG2N*TWW-1:0]     tw_addr;
    logic                     flush;
    logic                     out_valid;
    logic                     out_first;
    logic                     out_last;
    logic                     err;

    fft_sdf_sequencer #(.LOG2N(LOG2N), .STAGE_LAT(STAGE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stage_en  (stage_en),
        .bfly_sel  (bfly_sel),
        .tw_addr   (tw_addr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 flush, 3 abort.
    int m_mode  = 0;
    int m_pos   = 0;
    int m_fleft = 0;
    int m_cnt [LOG2N];
    int m_base  = 0;
    int gcyc    = 0;
    bit h_eff [HMAX];
    bit h_acc [HMAX];
    int h_idx [HMAX];

    logic                 s_rdy, s_flush, s_err, s_ov, s_of, s_ol;
    logic [LOG2N-1:0]     s_en, s_sel;
    logic [LOG2N*TWW-1:0] s_tw;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, gcyc, act, exp);
        end
    endtask

    function automatic bit eff_at(input int t);
        if (t < 0 || t < m_base) return 1'b0;
        return h_eff[t];
    endfunction

    function automatic bit acc_at(input int t);
        if (t < 0 || t < m_base) return 1'b0;
        return h_acc[t];
    endfunction

    task automatic step(input bit r, input bit iv);
        bit                   quiet, acc, e_flush, eff, e_err, e_rdy, e_ov, e_of, e_ol;
        logic [LOG2N-1:0]     en_raw, e_en, e_sel;
        logic [LOG2N*TWW-1:0] e_tw;
        int                   oidx;
        rst      = r;
        in_valid = iv;
        @(negedge clk);
        quiet   = r || (m_mode == 3);
        e_rdy   = r || (m_mode <= 1);
        acc     = !r && iv && (m_mode <= 1);
        e_flush = !r && ((m_mode == 2) || (m_mode == 1 && !iv && m_pos == 0));
        eff     = acc || e_flush;
        e_err   = !r && ((m_mode == 3) || (m_mode == 2 && iv));
        e_tw    = '0;
        for (int s = 0; s < LOG2N; s++) begin
            en_raw[s] = (s == 0) ? eff : eff_at(gcyc - s * STAGE_LAT);
            e_en[s]   = quiet ? 1'b0 : en_raw[s];
            e_sel[s]  = e_en[s] && (((m_cnt[s] >> (LOG2N - 1 - s)) & 1) == 1);
`ifdef FFT_SEQ_TWIDDLE_EN
            if (e_en[s] && !e_sel[s] && s < LOG2N - 1)
                e_tw[s*TWW +: TWW] = TWW'((m_cnt[s] % (1 << (LOG2N - 1 - s))) << s);
`endif
        end
        e_ov = !quiet && acc_at(gcyc - LATT);
        oidx = (gcyc - LATT >= 0) ? h_idx[(gcyc - LATT >= 0) ? gcyc - LATT : 0] : 0;
        e_of = e_ov && (oidx == 0);
        e_ol = e_ov && (oidx == N - 1);

        s_rdy = in_ready; s_flush = flush; s_err = err; s_en = stage_en;
        s_sel = bfly_sel; s_tw = tw_addr; s_ov = out_valid; s_of = out_first; s_ol = out_last;
        check("in_ready",  32'(s_rdy),   32'(e_rdy));
        check("flush",     32'(s_flush), 32'(e_flush));
        check("err",       32'(s_err),   32'(e_err));
        check("stage_en",  32'(s_en),    32'(e_en));
        check("bfly_sel",  32'(s_sel),   32'(e_sel));
        check("tw_addr",   32'(s_tw),    32'(e_tw));
        check("out_valid", 32'(s_ov),    32'(e_ov));
        check("out_first", 32'(s_of),    32'(e_of));
        check("out_last",  32'(s_ol),    32'(e_ol));

        h_eff[gcyc] = eff;
        h_acc[gcyc] = acc;
        h_idx[gcyc] = m_pos;
        for (int s = 0; s < LOG2N; s++)
            if (en_raw[s]) m_cnt[s] = (m_cnt[s] + 1) % N;
        if (r || m_mode == 3) begin
            m_mode = 0;
            m_pos  = 0;
            for (int s = 0; s < LOG2N; s++) m_cnt[s] = 0;
            m_base = gcyc + 1;
        end else begin
            case (m_mode)
                0: if (iv) begin m_mode = 1; m_pos = 1; end
                1: begin
                    if (iv) m_pos = (m_pos + 1) % N;
                    else if (m_pos == 0) begin m_mode = 2; m_fleft = LATT - 1; end
                    else m_mode = 3;
                end
                default: begin
                    m_fleft--;
                    if (m_fleft == 0) m_mode = 0;
                end
            endcase
        end
        gcyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int frames_left;
        bit r, iv;
        for (int s = 0; s < LOG2N; s++) m_cnt[s] = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Single frame
        for (int c = 0; c < 48; c++) begin
            step(1'b0, c < 16);
            if (c == 7)  check("d1_sel0_c7",  32'(s_sel[0]), 32'd0);
            if (c == 8)  check("d1_sel0_c8",  32'(s_sel[0]), 32'd1);
            if (c == 7)  check("d1_sel1_c7",  32'(s_sel[1]), 32'd1);
            if (c == 11) check("d1_sel1_c11", 32'(s_sel[1]), 32'd0);
            if (c == 16) check("d1_flush16",  32'(s_flush),  32'd1);
            if (c == 27) check("d1_first27",  32'(s_of),     32'd1);
            if (c == 42) check("d1_last42",   32'(s_ol),     32'd1);
            if (c == 43) check("d1_idle43",   32'({s_rdy, s_flush}), 32'b10);
`ifdef FFT_SEQ_TWIDDLE_EN
            if (c == 5)  check("d1_tw0_c5",   32'(s_tw[TWW-1:0]), 32'd5);
            if (c == 9)  check("d1_tw0_c9",   32'(s_tw[TWW-1:0]), 32'd0);
`else
            if (c < 16)  check("d1_tw_off",   32'(s_tw), 32'd0);
`endif
        end
        // Two back-to-back frames
        for (int c = 0; c < 64; c++) begin
            step(1'b0, c < 32);
            if (c == 31) check("d2_noflush31", 32'(s_flush), 32'd0);
            if (c == 43) check("d2_first43",   32'(s_of),    32'd1);
            if (c == 58) check("d2_last58",    32'(s_ol),    32'd1);
        end
        // Mid-frame gap
        for (int c = 0; c < 12; c++) begin
            step(1'b0, c < 5);
            if (c == 6) check("d3_err6",  32'(s_err), 32'd1);
            if (c == 7) check("d3_rdy7",  32'(s_rdy), 32'd1);
        end
        // Input offered during flush
        for (int c = 0; c < 46; c++) begin
            step(1'b0, c < 16 || c == 20);
            if (c == 20) check("d4_err20", 32'({s_rdy, s_err}), 32'b01);
            if (c == 42) check("d4_last42", 32'(s_ol), 32'd1);
        end
        // Reset mid-frame
        for (int c = 0; c < 56; c++) begin
            step(c == 8, c < 8 || (c >= 10 && c < 26));
            if (c == 9)  check("d5_quiet9",  32'({s_en, s_ov, s_err}), 32'd0);
            if (c == 37) check("d5_first37", 32'(s_of), 32'd1);
        end

        frames_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            case (m_mode)
                0: begin
                    iv = ($urandom_range(0, 2) == 0);
                    if (iv) frames_left = $urandom_range(1, 3);
                end
                1: begin
                    if (m_pos == 0 && frames_left == 0) iv = 1'b0;
                    else iv = ($urandom_range(0, 79) != 0);
                    if (iv && m_pos == N - 1) frames_left--;
                end
                2: iv = ($urandom_range(0, 9) == 0);
                default: iv = 1'($urandom_range(0, 1));
            endcase
            step(r, iv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
